// File: rtl/rv32_fetch_stage.sv
// rtl/rv32_fetch_stage.sv - rv32 instruction fetch stage: PC ownership, imem addressing, fetch/decode buffer
package rv32_fetch_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic        generate_nop;
  } fetch_decode_buffer_t;
endpackage

module rv32_fetch_stage
  import rv32_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 stall,
  input  logic                 stop,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_target,
  input  logic                 imem_ready,
  output logic                 imem_req,
  output logic [31:0]          imem_addr,
  output fetch_decode_buffer_t fetch_decode_buff,
  output logic                 fetch_misaligned
);

  logic [31:0] next_pc;
  logic [31:0] target_aligned;
  logic [31:0] addr_raw;
  logic        valid;

  assign valid          = !fetch_decode_buff.generate_nop;
  assign target_aligned = {branch_target[31:2], 2'b00};
  assign imem_addr      = {addr_raw[31:2], 2'b00};

  // Select the address presented to memory; a held instruction is re-read so
  // the memory output keeps matching the buffer pc seen by decode.
  always_comb begin
    imem_req = 1'b0;
    addr_raw = next_pc;
    if (!resetn) begin
      imem_req = 1'b0;
    end else if (stop) begin
      imem_req = valid;
      addr_raw = fetch_decode_buff.pc;
    end else if (branch_taken) begin
      imem_req = 1'b1;
      addr_raw = target_aligned;
    end else if (stall && valid) begin
      imem_req = 1'b1;
      addr_raw = fetch_decode_buff.pc;
    end else begin
      imem_req = 1'b1;
      addr_raw = next_pc;
    end
  end

  // Advance PC and buffer; a refused re-read turns into a bubble and rewinds
  // next_pc so the unconsumed instruction is fetched again.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fetch_decode_buff.pc           <= RESET_PC;
      fetch_decode_buff.generate_nop <= 1'b1;
      next_pc                        <= RESET_PC;
      fetch_misaligned               <= 1'b0;
    end else if (stop) begin
      if (valid && !imem_ready) begin
        fetch_decode_buff.generate_nop <= 1'b1;
        next_pc                        <= fetch_decode_buff.pc;
      end
    end else if (branch_taken) begin
      if (branch_target[1:0] != 2'b00) begin
        fetch_misaligned <= 1'b1;
      end
      if (imem_ready) begin
        fetch_decode_buff.pc           <= target_aligned;
        fetch_decode_buff.generate_nop <= 1'b0;
        next_pc                        <= target_aligned + 32'd4;
      end else begin
        fetch_decode_buff.generate_nop <= 1'b1;
        next_pc                        <= target_aligned;
      end
    end else if (stall && valid) begin
      if (!imem_ready) begin
        fetch_decode_buff.generate_nop <= 1'b1;
        next_pc                        <= fetch_decode_buff.pc;
      end
    end else begin
      if (imem_ready) begin
        fetch_decode_buff.pc           <= next_pc;
        fetch_decode_buff.generate_nop <= 1'b0;
        next_pc                        <= next_pc + 32'd4;
      end else begin
        fetch_decode_buff.generate_nop <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rv32_fetch_stage.sv
// tb/tb_rv32_fetch_stage.sv - directed self-checking bench for rv32_fetch_stage
module tb_rv32_fetch_stage;
  import rv32_fetch_pkg::*;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic                 stall;
  logic                 stop;
  logic                 branch_taken;
  logic [31:0]          branch_target;
  logic                 imem_ready;
  logic                 imem_req;
  logic [31:0]          imem_addr;
  fetch_decode_buffer_t fdb;
  logic                 fetch_misaligned;

  int total = 0;
  int bad   = 0;

  rv32_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .stall            (stall),
    .stop             (stop),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .imem_ready       (imem_ready),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .fetch_decode_buff(fdb),
    .fetch_misaligned (fetch_misaligned)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; stall = 1'b0; stop = 1'b0; branch_taken = 1'b0;
    branch_target = 32'h0; imem_ready = 1'b1;
    tick(); tick();
    total++; if (fdb.pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", fdb.pc, 32'h0); end
    total++; if (fdb.generate_nop !== 1'b1) begin bad++; $display("FAIL reset_nop got=%b exp=1", fdb.generate_nop); end
    total++; if (fetch_misaligned !== 1'b0) begin bad++; $display("FAIL reset_misaligned got=%b exp=0", fetch_misaligned); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", imem_req); end
  endtask

  task automatic test_stream();
    resetn = 1'b1; imem_ready = 1'b1;
    settle();
    for (int i = 0; i < 4; i++) begin
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin bad++; $display("FAIL stream_addr%0d got=%b/%h exp=1/%h", i, imem_req, imem_addr, 32'(4 * i)); end
      tick();
      total++; if (fdb.pc !== 32'(4 * i) || fdb.generate_nop !== 1'b0) begin bad++; $display("FAIL stream_buf%0d got=%h/%b exp=%h/0", i, fdb.pc, fdb.generate_nop, 32'(4 * i)); end
    end
  endtask

  task automatic test_wait_state();
    imem_ready = 1'b0;
    settle();
    for (int i = 0; i < 2; i++) begin
      total++; if (imem_addr !== 32'h10) begin bad++; $display("FAIL wait_addr%0d got=%h exp=%h", i, imem_addr, 32'h10); end
      tick();
      total++; if (fdb.generate_nop !== 1'b1 || fdb.pc !== 32'hC) begin bad++; $display("FAIL wait_bubble%0d got=%h/%b exp=%h/1", i, fdb.pc, fdb.generate_nop, 32'hC); end
    end
    imem_ready = 1'b1;
    settle();
    total++; if (imem_addr !== 32'h10) begin bad++; $display("FAIL wait_resume_addr got=%h exp=%h", imem_addr, 32'h10); end
    tick();
    total++; if (fdb.pc !== 32'h10 || fdb.generate_nop !== 1'b0) begin bad++; $display("FAIL wait_resume_buf got=%h/%b exp=%h/0", fdb.pc, fdb.generate_nop, 32'h10); end
  endtask

  task automatic test_stall_rewind();
    tick(); tick(); tick(); tick();
    total++; if (fdb.pc !== 32'h20 || fdb.generate_nop !== 1'b0) begin bad++; $display("FAIL stall_pre got=%h/%b exp=%h/0", fdb.pc, fdb.generate_nop, 32'h20); end
    stall = 1'b1; imem_ready = 1'b1;
    settle();
    for (int i = 0; i < 2; i++) begin
      total++; if (imem_addr !== 32'h20 || imem_req !== 1'b1) begin bad++; $display("FAIL stall_addr%0d got=%h/%b exp=%h/1", i, imem_addr, imem_req, 32'h20); end
      tick();
      total++; if (fdb.pc !== 32'h20 || fdb.generate_nop !== 1'b0) begin bad++; $display("FAIL stall_hold%0d got=%h/%b exp=%h/0", i, fdb.pc, fdb.generate_nop, 32'h20); end
    end
    imem_ready = 1'b0;
    settle();
    total++; if (imem_addr !== 32'h20) begin bad++; $display("FAIL stall_nr_addr got=%h exp=%h", imem_addr, 32'h20); end
    tick();
    total++; if (fdb.generate_nop !== 1'b1) begin bad++; $display("FAIL stall_nr_bubble got=%b exp=1", fdb.generate_nop); end
    stall = 1'b0; imem_ready = 1'b1;
    settle();
    total++; if (imem_addr !== 32'h20) begin bad++; $display("FAIL stall_refetch_addr got=%h exp=%h", imem_addr, 32'h20); end
    tick();
    total++; if (fdb.pc !== 32'h20 || fdb.generate_nop !== 1'b0) begin bad++; $display("FAIL stall_refetch got=%h/%b exp=%h/0", fdb.pc, fdb.generate_nop, 32'h20); end
    tick();
    total++; if (fdb.pc !== 32'h24 || fdb.generate_nop !== 1'b0) begin bad++; $display("FAIL stall_continue got=%h/%b exp=%h/0", fdb.pc, fdb.generate_nop, 32'h24); end
  endtask

  task automatic test_branch_during_stall();
    branch_taken = 1'b1; branch_target = 32'h100; stall = 1'b1;
    settle();
    total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL br_stall_addr got=%h exp=%h", imem_addr, 32'h100); end
    tick();
    total++; if (fdb.pc !== 32'h100 || fdb.generate_nop !== 1'b0) begin bad++; $display("FAIL br_stall_buf got=%h/%b exp=%h/0", fdb.pc, fdb.generate_nop, 32'h100); end
    branch_taken = 1'b0; stall = 1'b0;
    tick();
    total++; if (fdb.pc !== 32'h104 || fdb.generate_nop !== 1'b0) begin bad++; $display("FAIL br_stall_next got=%h/%b exp=%h/0", fdb.pc, fdb.generate_nop, 32'h104); end
  endtask

  task automatic test_stop_precedence();
    stop = 1'b1; branch_taken = 1'b1; branch_target = 32'h300;
    settle();
    for (int i = 0; i < 3; i++) begin
      total++; if (imem_addr !== 32'h104 || imem_req !== 1'b1) begin bad++; $display("FAIL stop_addr%0d got=%h/%b exp=%h/1", i, imem_addr, imem_req, 32'h104); end
      tick();
      total++; if (fdb.pc !== 32'h104 || fdb.generate_nop !== 1'b0) begin bad++; $display("FAIL stop_hold%0d got=%h/%b exp=%h/0", i, fdb.pc, fdb.generate_nop, 32'h104); end
    end
    stop = 1'b0;
    tick();
    total++; if (fdb.pc !== 32'h300 || fdb.generate_nop !== 1'b0) begin bad++; $display("FAIL stop_release got=%h/%b exp=%h/0", fdb.pc, fdb.generate_nop, 32'h300); end
    branch_taken = 1'b0;
    stop = 1'b1; imem_ready = 1'b0;
    tick();
    total++; if (fdb.generate_nop !== 1'b1 || fdb.pc !== 32'h300) begin bad++; $display("FAIL stop_nr_bubble got=%h/%b exp=%h/1", fdb.pc, fdb.generate_nop, 32'h300); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stop_bubble_req got=%b exp=0", imem_req); end
    imem_ready = 1'b1;
    tick();
    total++; if (fdb.generate_nop !== 1'b1) begin bad++; $display("FAIL stop_bubble_hold got=%b exp=1", fdb.generate_nop); end
    stop = 1'b0;
    settle();
    total++; if (imem_addr !== 32'h300) begin bad++; $display("FAIL stop_rewind_addr got=%h exp=%h", imem_addr, 32'h300); end
    tick();
    total++; if (fdb.pc !== 32'h300 || fdb.generate_nop !== 1'b0) begin bad++; $display("FAIL stop_refetch got=%h/%b exp=%h/0", fdb.pc, fdb.generate_nop, 32'h300); end
  endtask

  task automatic test_misaligned_wrap();
    branch_taken = 1'b1; branch_target = 32'h202;
    settle();
    total++; if (imem_addr !== 32'h200) begin bad++; $display("FAIL mis_addr got=%h exp=%h", imem_addr, 32'h200); end
    tick();
    total++; if (fdb.pc !== 32'h200 || fetch_misaligned !== 1'b1) begin bad++; $display("FAIL mis_buf got=%h/%b exp=%h/1", fdb.pc, fetch_misaligned, 32'h200); end
    branch_target = 32'hFFFF_FFFC;
    tick();
    total++; if (fdb.pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_target got=%h exp=%h", fdb.pc, 32'hFFFF_FFFC); end
    branch_taken = 1'b0;
    settle();
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr got=%h exp=%h", imem_addr, 32'h0); end
    tick();
    total++; if (fdb.pc !== 32'h0 || fdb.generate_nop !== 1'b0 || fetch_misaligned !== 1'b1) begin bad++; $display("FAIL wrap_buf got=%h/%b/%b exp=%h/0/1", fdb.pc, fdb.generate_nop, fetch_misaligned, 32'h0); end
    branch_taken = 1'b1; branch_target = 32'h400; imem_ready = 1'b0;
    tick();
    total++; if (fdb.generate_nop !== 1'b1 || fdb.pc !== 32'h0) begin bad++; $display("FAIL br_nr_bubble got=%h/%b exp=%h/1", fdb.pc, fdb.generate_nop, 32'h0); end
    branch_taken = 1'b0; imem_ready = 1'b1;
    settle();
    total++; if (imem_addr !== 32'h400) begin bad++; $display("FAIL br_nr_addr got=%h exp=%h", imem_addr, 32'h400); end
    tick();
    total++; if (fdb.pc !== 32'h400 || fdb.generate_nop !== 1'b0) begin bad++; $display("FAIL br_nr_buf got=%h/%b exp=%h/0", fdb.pc, fdb.generate_nop, 32'h400); end
  endtask

  task automatic test_reset_mid_stall();
    stall = 1'b1; resetn = 1'b0;
    settle();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_mid_req got=%b exp=0", imem_req); end
    tick();
    total++; if (fdb.pc !== 32'h0 || fdb.generate_nop !== 1'b1 || fetch_misaligned !== 1'b0) begin bad++; $display("FAIL rst_mid_state got=%h/%b/%b exp=%h/1/0", fdb.pc, fdb.generate_nop, fetch_misaligned, 32'h0); end
    resetn = 1'b1;
    settle();
    total++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin bad++; $display("FAIL rst_mid_addr got=%h/%b exp=%h/1", imem_addr, imem_req, 32'h0); end
    tick();
    total++; if (fdb.pc !== 32'h0 || fdb.generate_nop !== 1'b0) begin bad++; $display("FAIL rst_mid_first got=%h/%b exp=%h/0", fdb.pc, fdb.generate_nop, 32'h0); end
    stall = 1'b0;
  endtask

  initial begin
    #2;
    test_reset();
    test_stream();
    test_wait_state();
    test_stall_rewind();
    test_branch_during_stall();
    test_stop_precedence();
    test_misaligned_wrap();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
